// File: rtl/pwm_ramp_ctrl.sv
// Soft-start duty sequencer for a 2^BIT-cycle PWM: ramps duty_out toward a handshaken target at period boundaries.
// Define PWM_RAMP_SOFTSTOP_EN to ramp down on disable instead of cutting duty to 0 at the next period boundary.
module pwm_ramp_ctrl #(
    parameter int BIT      = 6,
    parameter int STEP     = 4,
    parameter int RAMP_DIV = 2
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           enable_in,
    input  logic [BIT-1:0] target_in,
    input  logic           target_valid_in,
    output logic           target_ready_out,
    output logic [BIT-1:0] duty_out,
    output logic           period_tick_out,
    output logic           busy_out,
    output logic           at_target_out
);

    localparam int                DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [BIT:0]      STEP_X   = (BIT+1)'(STEP);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOP} state_t;

    state_t           state;
    logic [BIT-1:0]   phase_cnt;
    logic [BIT-1:0]   target_reg;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             accept;
    logic [BIT-1:0]   ramp_next;

    // One step toward tgt, computed one bit wider so it can neither wrap nor overshoot.
    function automatic logic [BIT-1:0] step_toward(input logic [BIT-1:0] cur, input logic [BIT-1:0] tgt);
        logic [BIT:0] c, t, r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (c < t)
            r = ((c + STEP_X) >= t) ? t : (c + STEP_X);
        else
            r = ((c - t) <= STEP_X) ? t : (c - STEP_X);
        return r[BIT-1:0];
    endfunction

    assign tick             = (phase_cnt == {BIT{1'b1}});
    assign accept           = target_valid_in && target_ready_out;
    assign ramp_next        = step_toward(duty_out, target_reg);
    assign period_tick_out  = tick;
    assign target_ready_out = (state == IDLE) || (state == HOLD);
    assign busy_out         = (state == RAMP) || (state == STOP);
    assign at_target_out    = (state == HOLD) && (duty_out == target_reg);

`ifdef PWM_RAMP_SOFTSTOP_EN
    logic [BIT-1:0] stop_next;
    assign stop_next = step_toward(duty_out, '0);
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            phase_cnt <= '0;
        else
            phase_cnt <= phase_cnt + 1'b1;
    end

    // Duty only ever changes on a tick edge, so the PWM sees the new value from phase 0.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            duty_out   <= '0;
            div_cnt    <= '0;
            target_reg <= '0;
        end else begin
            if (accept)
                target_reg <= target_in;
            case (state)
                IDLE: begin
                    if (enable_in) begin
                        state   <= RAMP;
                        div_cnt <= '0;
                    end
                end
                RAMP, HOLD: begin
                    if (!enable_in) begin
`ifdef PWM_RAMP_SOFTSTOP_EN
                        state <= STOP;
`else
                        if (tick) begin
                            duty_out <= '0;
                            div_cnt  <= '0;
                            state    <= IDLE;
                        end
`endif
                    end else if (state == HOLD) begin
                        if (accept && (target_in != duty_out)) begin
                            state   <= RAMP;
                            div_cnt <= '0;
                        end
                    end else if (tick) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt  <= '0;
                            duty_out <= ramp_next;
                            if (ramp_next == target_reg)
                                state <= HOLD;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
`ifdef PWM_RAMP_SOFTSTOP_EN
                STOP: begin
                    if (enable_in) begin
                        state <= RAMP;
                    end else if (tick) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt  <= '0;
                            duty_out <= stop_next;
                            if (stop_next == '0)
                                state <= IDLE;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
